// File: rtl/heichips25_nibble_link_pkg.sv
// Shared definitions for the Snitch 4-bit serial memory link.
// Used by the far-end responder and by the chip-side serializer bench.
package heichips25_nibble_link_pkg;

  localparam int unsigned NibblesPerWord = 8;
  localparam int unsigned NibbleWidth    = 4;
  localparam int unsigned MaxAddrWidth   = 16;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WCOLLECT   = 2'd1,
    RSP_SEND   = 2'd2,
    RSP_COMMIT = 2'd3
  } state_e;

  // One request beat as seen on the link; addr is sized for the widest user.
  typedef struct packed {
    logic [MaxAddrWidth-1:0] addr;
    logic                    write;
    logic [NibbleWidth-1:0]  nibble;
    logic                    strb;
  } req_beat_t;

endpackage

// File: rtl/heichips25_nibble_mem.sv
// Local word memory for the nibble responder: 2**AddrWidth x 32 bits,
// combinational read, synchronous write with one enable per nibble.
// Contents are deliberately not reset.
module heichips25_nibble_mem
  import heichips25_nibble_link_pkg::*;
#(
  parameter int unsigned AddrWidth = 8
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [7:0]           nib_en_i,
  input  logic [AddrWidth-1:0] waddr_i,
  input  logic [31:0]          wdata_i,
  input  logic [AddrWidth-1:0] raddr_i,
  output logic [31:0]          rdata_o
);

  logic [31:0] mem_q [2**AddrWidth];

  assign rdata_o = mem_q[raddr_i];

  // Nibble-masked word write
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int unsigned k = 0; k < NibblesPerWord; k++) begin
        if (nib_en_i[k[2:0]]) begin
          mem_q[waddr_i][{k[2:0], 2'b00} +: NibbleWidth] <= wdata_i[{k[2:0], 2'b00} +: NibbleWidth];
        end
      end
    end
  end

endmodule

// File: rtl/heichips25_nibble_mem_responder.sv
// Far-end responder for the Snitch 4-bit serial memory link.
// Collects nibble-serial requests, executes them on a local word memory and
// streams read data back MSB nibble first, followed by a commit phase.
// Optional: HEICHIPS25_RSP_WRITE_ACK_EN makes writes answer with 8 zero
// nibbles plus a commit phase, exactly like a read.
module heichips25_nibble_mem_responder
  import heichips25_nibble_link_pkg::*;
#(
  parameter int unsigned AddrWidth    = 8,
  parameter int unsigned CommitCycles = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic                 req_write_i,
  input  logic [3:0]           req_nibble_i,
  input  logic                 req_strb_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  output logic [3:0]           rsp_nibble_o,
  output logic                 rsp_valid_o,
  output logic                 rsp_last_o,
  input  logic                 rsp_ready_i
);

  localparam logic [2:0] LastIdx = 3'(NibblesPerWord - 1);

  state_e               state_q;
  logic [2:0]           cnt_q;
  logic [2:0]           commit_q;
  logic [AddrWidth-1:0] addr_q;
  logic [31:0]          wdata_q;
  logic [7:0]           strb_q;
  logic [31:0]          shift_q;

  logic        req_fire;
  logic        rsp_fire;
  logic        wr_commit;
  logic [31:0] wr_data;
  logic [7:0]  wr_en;
  logic [31:0] rd_data;

  // Output decode; everything is held low while reset is asserted
  always_comb begin
    req_ready_o  = 1'b0;
    rsp_valid_o  = 1'b0;
    rsp_nibble_o = '0;
    rsp_last_o   = 1'b0;
    if (!rst_i) begin
      case (state_q)
        IDLE, WCOLLECT: req_ready_o = 1'b1;
        RSP_SEND: begin
          rsp_valid_o  = 1'b1;
          rsp_nibble_o = shift_q[31:28];
          rsp_last_o   = (cnt_q == LastIdx);
        end
        RSP_COMMIT: rsp_valid_o = 1'b1;
        default: ;
      endcase
    end
  end

  assign req_fire  = req_valid_i & req_ready_o;
  assign rsp_fire  = rsp_valid_o & rsp_ready_i;
  assign wr_commit = req_fire && (state_q == WCOLLECT) && (cnt_q == LastIdx);

  // Final write word: collected slots merged with the beat arriving this cycle
  always_comb begin
    wr_data = wdata_q;
    wr_en   = strb_q;
    wr_data[{cnt_q, 2'b00} +: 4] = req_nibble_i;
    wr_en[cnt_q]                 = req_strb_i;
  end

  heichips25_nibble_mem #(
    .AddrWidth(AddrWidth)
  ) u_mem (
    .clk_i    (clk_i),
    .we_i     (wr_commit),
    .nib_en_i (wr_en),
    .waddr_i  (addr_q),
    .wdata_i  (wr_data),
    .raddr_i  (req_addr_i),
    .rdata_o  (rd_data)
  );

  // Transaction FSM with collect, shift and commit counters
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      commit_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      strb_q   <= '0;
      shift_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_fire) begin
            addr_q <= req_addr_i;
            if (req_write_i) begin
              wdata_q <= {28'h0, req_nibble_i};
              strb_q  <= {7'h0, req_strb_i};
              cnt_q   <= 3'd1;
              state_q <= WCOLLECT;
            end else begin
              shift_q <= rd_data;
              cnt_q   <= '0;
              state_q <= RSP_SEND;
            end
          end
        end
        WCOLLECT: begin
          if (req_fire) begin
            wdata_q[{cnt_q, 2'b00} +: 4] <= req_nibble_i;
            strb_q[cnt_q]                <= req_strb_i;
            // wraps to 0 after slot 7, which is the start value for RSP_SEND
            cnt_q                        <= cnt_q + 3'd1;
            if (cnt_q == LastIdx) begin
`ifdef HEICHIPS25_RSP_WRITE_ACK_EN
              shift_q <= '0;
              state_q <= RSP_SEND;
`else
              state_q <= IDLE;
`endif
            end
          end
        end
        RSP_SEND: begin
          if (rsp_fire) begin
            shift_q <= {shift_q[27:0], 4'h0};
            cnt_q   <= cnt_q + 3'd1;
            if (cnt_q == LastIdx) begin
              commit_q <= 3'(CommitCycles);
              state_q  <= RSP_COMMIT;
            end
          end
        end
        RSP_COMMIT: begin
          if (commit_q == 3'd1) begin
            state_q <= IDLE;
          end else begin
            commit_q <= commit_q - 3'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_heichips25_nibble_mem_responder.sv
// Self-checking bench for heichips25_nibble_mem_responder: directed scenarios
// followed by randomized traffic, checked every cycle against a transaction
// level model (word array + queue of expected response beats).
module tb_heichips25_nibble_mem_responder;

  localparam int unsigned CC = 2;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [7:0] req_addr_i;
  logic       req_write_i;
  logic [3:0] req_nibble_i;
  logic       req_strb_i;
  logic       req_valid_i;
  logic       req_ready_o;
  logic [3:0] rsp_nibble_o;
  logic       rsp_valid_o;
  logic       rsp_last_o;
  logic       rsp_ready_i;

  always #5 clk = ~clk;

  heichips25_nibble_mem_responder #(
    .AddrWidth(8),
    .CommitCycles(CC)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .req_addr_i   (req_addr_i),
    .req_write_i  (req_write_i),
    .req_nibble_i (req_nibble_i),
    .req_strb_i   (req_strb_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .rsp_nibble_o (rsp_nibble_o),
    .rsp_valid_o  (rsp_valid_o),
    .rsp_last_o   (rsp_last_o),
    .rsp_ready_i  (rsp_ready_i)
  );

  // ---------------- transaction-level model ----------------
  typedef struct {
    logic [3:0] nib;
    logic       last;
    logic       commit;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_mem [256];
  bit          col_active = 1'b0;
  int unsigned col_cnt;
  logic [7:0]  col_addr;
  logic [31:0] col_data;
  logic [7:0]  col_strb;
  logic [31:0] tmp_word;

  function automatic void push_word(input logic [31:0] w);
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      e.nib    = w[31-4*i -: 4];
      e.last   = (i == 7);
      e.commit = 1'b0;
      exp_q.push_back(e);
    end
    for (int i = 0; i < int'(CC); i++) begin
      e.nib    = 4'h0;
      e.last   = 1'b0;
      e.commit = 1'b1;
      exp_q.push_back(e);
    end
  endfunction

  always @(posedge clk) begin
    if (rst_i) begin
      exp_q.delete();
      col_active = 1'b0;
    end else if (exp_q.size() != 0) begin
      if (exp_q[0].commit || rsp_ready_i) void'(exp_q.pop_front());
    end else if (req_valid_i) begin
      if (col_active) begin
        col_data[4*col_cnt +: 4] = req_nibble_i;
        col_strb[col_cnt]        = req_strb_i;
        if (col_cnt == 7) begin
          tmp_word = model_mem[col_addr];
          for (int k = 0; k < 8; k++)
            if (col_strb[k]) tmp_word[4*k +: 4] = col_data[4*k +: 4];
          model_mem[col_addr] = tmp_word;
          col_active = 1'b0;
`ifdef HEICHIPS25_RSP_WRITE_ACK_EN
          push_word(32'h0);
`endif
        end else begin
          col_cnt++;
        end
      end else if (req_write_i) begin
        col_active = 1'b1;
        col_addr   = req_addr_i;
        col_data   = {28'h0, req_nibble_i};
        col_strb   = {7'h0, req_strb_i};
        col_cnt    = 1;
      end else begin
        push_word(model_mem[req_addr_i]);
      end
    end
  end

  // ---------------- checker / driver process ----------------
  int          tests = 0;
  int          fails = 0;
  bit          chk_en = 1'b0;
  bit          rnd_rdy = 1'b0;
  logic        last_ready;
  logic [31:0] acc = '0;
  logic [31:0] cap_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: compare at the falling edge, then drive just after the rising edge.
  task automatic tick();
    @(negedge clk);
    if (chk_en) begin
      chk("req_ready", {31'h0, req_ready_o}, {31'h0, (exp_q.size() == 0) && !rst_i});
      if (exp_q.size() != 0) begin
        chk("rsp_valid", {31'h0, rsp_valid_o}, 32'h1);
        chk("rsp_nibble", {28'h0, rsp_nibble_o}, {28'h0, exp_q[0].nib});
        chk("rsp_last", {31'h0, rsp_last_o}, {31'h0, exp_q[0].last});
      end else begin
        chk("rsp_idle_valid", {31'h0, rsp_valid_o}, 32'h0);
      end
    end
    last_ready = req_ready_o;
    if (!rst_i && rsp_valid_o && rsp_ready_i) begin
      acc = {acc[27:0], rsp_nibble_o};
      if (rsp_last_o) cap_q.push_back(acc);
    end
    @(posedge clk);
    #1;
    if (rnd_rdy) rsp_ready_i = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send_beat(input logic [7:0] a, input logic w, input logic [3:0] n,
                           input logic s, output int waited);
    bit ok = 1'b0;
    req_addr_i   = a;
    req_write_i  = w;
    req_nibble_i = n;
    req_strb_i   = s;
    req_valid_i  = 1'b1;
    waited = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick();
      waited++;
      if (last_ready) ok = 1'b1;
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL beat_accept: got no accept expected accept within 200 cycles");
    end
  endtask

  task automatic write_word(input logic [7:0] a, input logic [31:0] d,
                            input logic [7:0] s, input int nbeats);
    int wt;
    for (int k = 0; k < nbeats; k++) send_beat(a, 1'b1, d[4*k +: 4], s[k], wt);
  endtask

  task automatic read_word(input logic [7:0] a, output int waited);
    send_beat(a, 1'b0, 4'h0, 1'b0, waited);
  endtask

  task automatic wait_cap(input int n);
    for (int i = 0; i < 300 && cap_q.size() < n; i++) tick();
    chk("response_count", cap_q.size(), n);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      tick();
      if (last_ready) ok = 1'b1;
    end
    chk("return_to_idle", {31'h0, ok}, 32'h1);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  logic [7:0] pool [8];

  initial begin
    int          wt;
    logic [7:0]  a;
    logic [31:0] d;
    rst_i        = 1'b1;
    req_valid_i  = 1'b0;
    req_addr_i   = '0;
    req_write_i  = 1'b0;
    req_nibble_i = '0;
    req_strb_i   = 1'b0;
    rsp_ready_i  = 1'b1;

    // Reset
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    tick();
    tick();
    rst_i = 1'b0;
    tick();
    chk("reset_rsp_valid", {31'h0, rsp_valid_o}, 32'h0);
    chk("reset_rsp_nibble", {28'h0, rsp_nibble_o}, 32'h0);
    chk("reset_rsp_last", {31'h0, rsp_last_o}, 32'h0);
    chk("reset_req_ready", {31'h0, req_ready_o}, 32'h1);

    // Full write then read back
    write_word(8'h10, 32'hDEADBEEF, 8'hFF, 8);
    req_valid_i = 1'b0;
    chk("model_full_write", model_mem[8'h10], 32'hDEADBEEF);
    read_word(8'h10, wt);
    req_valid_i = 1'b0;
    wait_cap(1);
    chk("read_full", cap_q[0], 32'hDEADBEEF);
    wait_idle();

    // Partial write, low two nibbles only
    write_word(8'h10, 32'h11223344, 8'h03, 8);
    req_valid_i = 1'b0;
    chk("model_partial_write", model_mem[8'h10], 32'hDEADBE44);
    read_word(8'h10, wt);
    req_valid_i = 1'b0;
    wait_cap(2);
    chk("read_partial", cap_q[1], 32'hDEADBE44);
    wait_idle();

    // Response backpressure at nibble 4
    read_word(8'h10, wt);
    req_valid_i = 1'b0;
    repeat (4) tick();
    chk("stall_nibble_before", {28'h0, rsp_nibble_o}, 32'hB);
    rsp_ready_i = 1'b0;
    repeat (3) tick();
    chk("stall_nibble_held", {28'h0, rsp_nibble_o}, 32'hB);
    chk("stall_valid_held", {31'h0, rsp_valid_o}, 32'h1);
    chk("stall_last_held", {31'h0, rsp_last_o}, 32'h0);
    rsp_ready_i = 1'b1;
    wait_cap(3);
    chk("read_after_stall", cap_q[2], 32'hDEADBE44);
    wait_idle();

    // Back-to-back: read right after write beat 8, then a request that must stall
    write_word(8'h30, 32'hA5C396E1, 8'hFF, 8);
    read_word(8'h30, wt);
    chk("b2b_read_accept_wait", wt, 1);
    read_word(8'h10, wt);
    chk("stalled_request_wait", wt, 9 + CC);
    req_valid_i = 1'b0;
    wait_cap(5);
    chk("b2b_new_data", cap_q[3], 32'hA5C396E1);
    chk("b2b_second_read", cap_q[4], 32'hDEADBE44);
    wait_idle();

    // Reset after write beat 5 of 8
    write_word(8'h10, 32'h12345678, 8'hFF, 5);
    req_valid_i = 1'b0;
    rst_i = 1'b1;
    tick();
    chk("midreset_ready", {31'h0, req_ready_o}, 32'h0);
    chk("midreset_valid", {31'h0, rsp_valid_o}, 32'h0);
    rst_i = 1'b0;
    tick();
    read_word(8'h10, wt);
    req_valid_i = 1'b0;
    wait_cap(6);
    chk("read_after_abort", cap_q[5], 32'hDEADBE44);
    wait_idle();

    // Write acknowledgement (or its absence)
    write_word(8'h20, 32'hAAAA5555, 8'hFF, 8);
    req_valid_i = 1'b0;
`ifdef HEICHIPS25_RSP_WRITE_ACK_EN
    wait_cap(7);
    chk("write_ack_word", cap_q[6], 32'h0);
`else
    repeat (20) tick();
    chk("write_no_response", cap_q.size(), 6);
`endif
    wait_idle();

    // Randomized traffic over a pool of initialised addresses
    pool = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFE, 8'hFF, 8'h10, 8'h30};
    for (int i = 0; i < 6; i++) write_word(pool[i], $urandom, 8'hFF, 8);
    rnd_rdy = 1'b1;
    for (int i = 0; i < 60; i++) begin
      a = pool[$urandom_range(0, 7)];
      if ($urandom_range(0, 1) == 0) begin
        read_word(a, wt);
      end else begin
        d = $urandom;
        write_word(a, d, 8'($urandom), 8);
      end
      if ($urandom_range(0, 3) == 0) begin
        req_valid_i = 1'b0;
        tick();
      end
    end
    req_valid_i = 1'b0;
    wait_idle();
    rnd_rdy     = 1'b0;
    rsp_ready_i = 1'b1;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/heichips25_nibble_mem_responder.md
Name: heichips25_nibble_mem_responder

Overview:
- Far-end (eFPGA-side) responder for the Snitch 4-bit serial memory link.
- Accepts nibble-serialized read/write requests from the chip-side request serializer and executes them on a local word memory.
- Returns read data as 8 nibbles, MSB first, with a last flag, followed by a commit phase.
- Used as the link endpoint in the eFPGA fabric and as the bench model for chip-level simulation.

Parameters:
AddrWidth, 8, word-address width; memory depth = 2**AddrWidth words of 32 bits
CommitCycles, 2, cycles rsp_valid_o is held in the commit phase after the last nibble (range 1..7)

Ports:
clk_i  input  1  clock
rst_i  input  1  reset, synchronous, active-high
req_addr_i  input  AddrWidth  word address; sampled on first accepted beat only
req_write_i  input  1  1=write (8 beats), 0=read (1 beat); sampled on first beat
req_nibble_i  input  4  write data nibble, LSB nibble first
req_strb_i  input  1  per-nibble write enable
req_valid_i  input  1  request beat valid
req_ready_o  output  1  request beat accepted when valid&ready
rsp_nibble_o  output  4  read data nibble, MSB nibble first
rsp_valid_o  output  1  response beat / commit valid
rsp_last_o  output  1  marks 8th data nibble
rsp_ready_i  input  1  response nibble accepted when valid&ready

Behaviour:
- One clock; reset is synchronous and active-high (clk_i, rst_i).
- Reset: state IDLE, counters 0, shift/collect registers 0, all outputs 0. Memory contents are not reset.
- Reset mid-operation aborts the transaction with no partial memory write.
- FSM states: IDLE, WCOLLECT, RSP_SEND, RSP_COMMIT.
- IDLE: req_ready_o=1.
  - Accepted beat with write=0: latch addr; capture mem[addr] into rsp shift register at the same edge; next state RSP_SEND; cnt=0.
  - Accepted beat with write=1: latch addr; store nibble/strb into slot 0; cnt=1; next state WCOLLECT.
- WCOLLECT: req_ready_o=1; req_write_i/req_addr_i ignored.
  - Each accepted beat stores into slot cnt; cnt++.
  - Beat with cnt==7 accepted: write mem[addr] at that edge, nibble-granular (nibble k updated iff strb slot k=1); next state IDLE.
  - All-zero strb leaves memory unchanged.
- RSP_SEND: req_ready_o=0; rsp_valid_o=1; rsp_nibble_o=shift[31:28]; rsp_last_o=(cnt==7).
  - On rsp_ready_i: shift left 4, cnt++.
  - Last beat accepted: next state RSP_COMMIT; commit counter = CommitCycles.
  - rsp_ready_i low: hold nibble, last, and valid stable.
- RSP_COMMIT: req_ready_o=0; rsp_valid_o=1; rsp_last_o=0; rsp_nibble_o=0; rsp_ready_i ignored.
  - Counter decrements each cycle; at 1, next state IDLE.
- Latency:
  - Read accept edge to first rsp_valid_o: 1 cycle.
  - Full read occupies ≥ 1+8+CommitCycles cycles.
  - Write takes effect at the edge accepting beat 8; a read accepted the following cycle returns new data.
- Writes produce no response (default build).
- Address wrap: req_addr_i indexes modulo depth; no out-of-range error.
- Only one transaction in flight; no new request accepted until IDLE.

Optional Feature:
- Macro: HEICHIPS25_RSP_WRITE_ACK_EN
- Defined: after the write commit edge, enter RSP_SEND with shift=32'h0 (8 zero nibbles, last on 8th), then RSP_COMMIT, as for a read.
- Undefined: writes return directly to IDLE with no response beats.

Decomposition:
- Package heichips25_nibble_link_pkg:
  - state enum: IDLE, WCOLLECT, RSP_SEND, RSP_COMMIT
  - NibblesPerWord=8, NibbleWidth=4
  - req beat struct: addr, write, nibble, strb
- Package is shared with the chip-side serializer bench.
- One sub-module: heichips25_nibble_mem, a 2**AddrWidth x 32 array with combinational read and synchronous nibble-masked write (8-bit nibble enable).

Test Plan:
- Full write: addr 8'h10, data 32'hDEADBEEF, all strb=1, nibbles F,E,E,B,D,A,E,D -> 8 beats accepted; then read 8'h10 -> rsp nibbles D,E,A,D,B,E,E,F, last on 8th, then 2 commit cycles valid, nibble 0, and req_ready_o=0 throughout the response.
- Partial write to 8'h10 with data 32'h11223344, strb slots 0..1 set only -> subsequent read returns 32'hDEADBE44.
- Response backpressure: rsp_ready_i low for 3 cycles at nibble 4 -> nibble and last held stable; no beat skipped or duplicated.
- Back-to-back: read issued the cycle after write beat 8 to the same address -> returns newly written data; request beats presented during RSP_SEND/COMMIT stall (req_ready_o=0).
- rst_i pulsed after write beat 5 of 8 -> state IDLE, outputs 0, memory word unchanged; next read returns old value.
- HEICHIPS25_RSP_WRITE_ACK_EN defined: write to 8'h20 -> 8 zero nibbles, last on 8th, then commit phase; macro undefined -> no rsp_valid_o after the write.
